// File: rtl/eth_ping_responder_pkg.sv
// Shared types and constants for the ping responder coordinator and its pending-ping FIFO.
package eth_ping_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_TX = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  typedef struct packed {
    logic [15:0] id;
    logic [15:0] psize;
    logic [47:0] mac;
    logic [31:0] ip;
  } ping_desc_t;

  localparam logic [47:0] MAC_BROADCAST = 48'hFFFF_FFFF_FFFF;

  function automatic logic mac_accepts(input logic [47:0] dst, input logic [47:0] own);
    return (dst == own) || (dst == MAC_BROADCAST);
  endfunction

endpackage

// File: rtl/eth_ping_responder_fifo.sv
// First-word-fall-through queue of pending ping descriptors; flush empties it in one cycle.
module eth_ping_responder_fifo
  import eth_ping_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flush,
  input  logic       push,
  input  ping_desc_t din,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output ping_desc_t head
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int LW = AW + 1;

  ping_desc_t    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [LW-1:0] level;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LW'(FIFO_DEPTH));
  assign empty   = (level == LW'(0));
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= AW'(0);
      rd_ptr <= AW'(0);
      level  <= LW'(0);
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Descriptor storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/eth_ping_responder_coord.sv
// Responder-side ping coordinator: queues parsed pings and paces one pong per ping.
// Define ETH_PING_RESPONDER_FILTER_EN to accept only pings addressed to us or to broadcast.
module eth_ping_responder_coord
  import eth_ping_responder_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] timeout,
  input  logic [31:0] holdoff,
  input  logic [47:0] mac_addr_own,
  input  logic [31:0] ip_addr_own,
  input  logic        rx_valid,
  input  logic [15:0] rx_ping_id,
  input  logic [15:0] rx_psize,
  input  logic [47:0] rx_mac_src,
  input  logic [47:0] rx_mac_dst,
  input  logic [31:0] rx_ip_src,
  output logic        tx_trigger,
  input  logic        tx_begin,
  output logic [15:0] tx_ping_id,
  output logic [15:0] tx_psize,
  output logic [47:0] mac_addr_src,
  output logic [47:0] mac_addr_dst,
  output logic [31:0] ip_addr_src,
  output logic [31:0] ip_addr_dst,
  output logic        done,
  output logic [63:0] pongs_sent,
  output logic [63:0] pings_dropped,
  output logic [63:0] tx_timeouts
);

  state_t      state;
  logic [31:0] count;
  logic        accept;
  logic        fifo_full;
  logic        fifo_empty;
  logic        fifo_push;
  logic        fifo_pop;
  logic        fifo_flush;
  ping_desc_t  rx_desc;
  ping_desc_t  head;

`ifdef ETH_PING_RESPONDER_FILTER_EN
  assign accept = rx_valid && enable && mac_accepts(rx_mac_dst, mac_addr_own);
`else
  logic unused_mac_dst;
  assign unused_mac_dst = ^rx_mac_dst;
  assign accept = rx_valid && enable;
`endif

  assign rx_desc    = {rx_ping_id, rx_psize, rx_mac_src, rx_ip_src};
  // A full queue drops the ping even when a pop frees a slot on the same edge.
  assign fifo_push  = accept && !fifo_full;
  assign fifo_pop   = (state == ST_IDLE) && enable && !fifo_empty;
  assign fifo_flush = (state == ST_IDLE) && !enable;

  eth_ping_responder_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .flush(fifo_flush),
    .push (fifo_push),
    .din  (rx_desc),
    .pop  (fifo_pop),
    .full (fifo_full),
    .empty(fifo_empty),
    .head (head)
  );

  // Transaction FSM with registered pong fields, pulses and statistics.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      count         <= 32'd1;
      tx_trigger    <= 1'b0;
      done          <= 1'b0;
      tx_ping_id    <= 16'd0;
      tx_psize      <= 16'd0;
      mac_addr_src  <= 48'd0;
      mac_addr_dst  <= 48'd0;
      ip_addr_src   <= 32'd0;
      ip_addr_dst   <= 32'd0;
      pongs_sent    <= 64'd0;
      pings_dropped <= 64'd0;
      tx_timeouts   <= 64'd0;
    end else begin
      tx_trigger <= 1'b0;
      done       <= 1'b0;
      if (accept && fifo_full) pings_dropped <= pings_dropped + 64'd1;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            tx_ping_id   <= head.id;
            tx_psize     <= head.psize;
            mac_addr_src <= mac_addr_own;
            mac_addr_dst <= head.mac;
            ip_addr_src  <= ip_addr_own;
            ip_addr_dst  <= head.ip;
            tx_trigger   <= 1'b1;
            count        <= 32'd1;
            state        <= ST_WAIT_TX;
          end
        end
        ST_WAIT_TX: begin
          if (tx_begin) begin
            done       <= 1'b1;
            pongs_sent <= pongs_sent + 64'd1;
            count      <= 32'd1;
            state      <= ST_HOLDOFF;
          end else if (count >= timeout) begin
            done        <= 1'b1;
            tx_timeouts <= tx_timeouts + 64'd1;
            count       <= 32'd1;
            state       <= ST_HOLDOFF;
          end else begin
            count <= count + 32'd1;
          end
        end
        ST_HOLDOFF: begin
          if (count >= holdoff) begin
            state <= ST_IDLE;
          end else begin
            count <= count + 32'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          count <= 32'd1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eth_ping_responder_coord.sv
// Self-checking bench for eth_ping_responder_coord: directed tables, corner sequences and a
// randomized run against a timestamp-based reference model.
module tb_eth_ping_responder_coord;
  import eth_ping_responder_pkg::*;

  localparam int          DEPTH   = 4;
  localparam logic [47:0] OWN_MAC = 48'h02_11_22_33_44_55;
  localparam logic [31:0] OWN_IP  = 32'hC0A8_0001;
  localparam logic [47:0] BCAST   = 48'hFFFF_FFFF_FFFF;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] timeout;
  logic [31:0] holdoff;
  logic [47:0] mac_addr_own;
  logic [31:0] ip_addr_own;
  logic        rx_valid;
  logic [15:0] rx_ping_id;
  logic [15:0] rx_psize;
  logic [47:0] rx_mac_src;
  logic [47:0] rx_mac_dst;
  logic [31:0] rx_ip_src;
  logic        tx_trigger;
  logic        tx_begin;
  logic [15:0] tx_ping_id;
  logic [15:0] tx_psize;
  logic [47:0] mac_addr_src;
  logic [47:0] mac_addr_dst;
  logic [31:0] ip_addr_src;
  logic [31:0] ip_addr_dst;
  logic        done;
  logic [63:0] pongs_sent;
  logic [63:0] pings_dropped;
  logic [63:0] tx_timeouts;

  eth_ping_responder_coord #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .enable(enable), .timeout(timeout), .holdoff(holdoff),
    .mac_addr_own(mac_addr_own), .ip_addr_own(ip_addr_own),
    .rx_valid(rx_valid), .rx_ping_id(rx_ping_id), .rx_psize(rx_psize),
    .rx_mac_src(rx_mac_src), .rx_mac_dst(rx_mac_dst), .rx_ip_src(rx_ip_src),
    .tx_trigger(tx_trigger), .tx_begin(tx_begin), .tx_ping_id(tx_ping_id), .tx_psize(tx_psize),
    .mac_addr_src(mac_addr_src), .mac_addr_dst(mac_addr_dst),
    .ip_addr_src(ip_addr_src), .ip_addr_dst(ip_addr_dst), .done(done),
    .pongs_sent(pongs_sent), .pings_dropped(pings_dropped), .tx_timeouts(tx_timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  // Reference model: queue of pending pings plus cycle timestamps of the current transaction.
  ping_desc_t  mq[$];
  longint      cyc;
  longint      m_idle_at;
  longint      m_t_trig;
  bit          m_in_wait;
  bit          m_trig;
  bit          m_done;
  logic [63:0] m_pongs;
  logic [63:0] m_dropped;
  logic [63:0] m_tos;
  ping_desc_t  m_fields;
  logic [47:0] m_msrc;
  logic [31:0] m_isrc;

  typedef struct {
    bit          rxv;
    bit          txb;
    logic [15:0] id;
    logic [7:0]  lo;
    bit          e_trig;
    bit          e_done;
    logic [63:0] e_pongs;
    logic [63:0] e_drop;
  } vec_t;

  vec_t tbl[13];

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic ping_desc_t mk(input logic [15:0] id, input logic [15:0] ps, input logic [7:0] lo);
    ping_desc_t d;
    d.id    = id;
    d.psize = ps;
    d.mac   = {40'h02_00_00_00_00, lo};
    d.ip    = {24'h0A_00_00, lo};
    return d;
  endfunction

  function automatic vec_t row(input bit rxv, input bit txb, input logic [15:0] id, input logic [7:0] lo,
                               input bit t, input bit d, input logic [63:0] p, input logic [63:0] dr);
    vec_t v;
    v.rxv = rxv; v.txb = txb; v.id = id; v.lo = lo;
    v.e_trig = t; v.e_done = d; v.e_pongs = p; v.e_drop = dr;
    return v;
  endfunction

  function automatic void model_step(input bit rxv, input bit txb, input bit en,
                                     input ping_desc_t d, input logic [47:0] dst);
    int unsigned sz;
    bit          acc;
    longint      hold;
    sz     = mq.size();
    m_trig = 1'b0;
    m_done = 1'b0;
    hold   = (holdoff == 32'd0) ? 64'sd1 : longint'(holdoff);
    if (m_in_wait) begin
      if (txb) begin
        m_pongs = m_pongs + 64'd1; m_done = 1'b1; m_in_wait = 1'b0; m_idle_at = cyc + 1 + hold;
      end else if ((cyc - m_t_trig + 1) >= longint'(timeout)) begin
        m_tos = m_tos + 64'd1; m_done = 1'b1; m_in_wait = 1'b0; m_idle_at = cyc + 1 + hold;
      end
    end else if (cyc >= m_idle_at) begin
      if (!en) begin
        mq.delete();
      end else if (sz != 0) begin
        m_fields  = mq.pop_front();
        m_msrc    = mac_addr_own;
        m_isrc    = ip_addr_own;
        m_trig    = 1'b1;
        m_in_wait = 1'b1;
        m_t_trig  = cyc + 1;
      end
    end
`ifdef ETH_PING_RESPONDER_FILTER_EN
    acc = rxv && en && ((dst == OWN_MAC) || (dst == BCAST));
`else
    acc = rxv && en && (dst == dst);
`endif
    if (acc) begin
      if (sz >= DEPTH) m_dropped = m_dropped + 64'd1;
      else mq.push_back(d);
    end
  endfunction

  function automatic void compare_all();
    chk("tx_trigger", 64'(tx_trigger), 64'(m_trig));
    chk("done", 64'(done), 64'(m_done));
    chk("pongs_sent", pongs_sent, m_pongs);
    chk("pings_dropped", pings_dropped, m_dropped);
    chk("tx_timeouts", tx_timeouts, m_tos);
    chk("tx_ping_id", 64'(tx_ping_id), 64'(m_fields.id));
    chk("tx_psize", 64'(tx_psize), 64'(m_fields.psize));
    chk("mac_addr_dst", 64'(mac_addr_dst), 64'(m_fields.mac));
    chk("ip_addr_dst", 64'(ip_addr_dst), 64'(m_fields.ip));
    chk("mac_addr_src", 64'(mac_addr_src), 64'(m_msrc));
    chk("ip_addr_src", 64'(ip_addr_src), 64'(m_isrc));
  endfunction

  task automatic step(input bit rxv, input ping_desc_t d, input logic [47:0] dst, input bit en, input bit txb);
    rx_valid   = rxv;
    rx_ping_id = d.id;
    rx_psize   = d.psize;
    rx_mac_src = d.mac;
    rx_ip_src  = d.ip;
    rx_mac_dst = dst;
    enable     = en;
    tx_begin   = txb;
    model_step(rxv, txb, en, d, dst);
    cyc++;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic idle(input int n, input bit en);
    for (int i = 0; i < n; i++) step(1'b0, mk(16'd0, 16'd0, 8'd0), OWN_MAC, en, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1; rx_valid = 1'b0; tx_begin = 1'b0; enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    mq.delete();
    cyc = 0; m_idle_at = 0; m_t_trig = 0; m_in_wait = 1'b0; m_trig = 1'b0; m_done = 1'b0;
    m_pongs = 64'd0; m_dropped = 64'd0; m_tos = 64'd0;
    m_fields = '0; m_msrc = 48'd0; m_isrc = 32'd0;
    compare_all();
  endtask

  task automatic run_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      step(tbl[i].rxv, mk(tbl[i].id, 16'd64, tbl[i].lo), OWN_MAC, 1'b1, tbl[i].txb);
      chk("tbl_trigger", 64'(tx_trigger), 64'(tbl[i].e_trig));
      chk("tbl_done", 64'(done), 64'(tbl[i].e_done));
      chk("tbl_pongs", pongs_sent, tbl[i].e_pongs);
      chk("tbl_dropped", pings_dropped, tbl[i].e_drop);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int ntrig;
    int r;
    logic [47:0] dst;
    vectors = 0; miscompares = 0;
    mac_addr_own = OWN_MAC; ip_addr_own = OWN_IP;
    rx_ping_id = 16'd0; rx_psize = 16'd0; rx_mac_src = 48'd0; rx_mac_dst = 48'd0; rx_ip_src = 32'd0;

    // single ping: tx_begin three cycles after the trigger
    tbl[0]  = row(1'b1, 1'b0, 16'h0005, 8'h0A, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[1]  = row(1'b0, 1'b0, 16'h0000, 8'h00, 1'b1, 1'b0, 64'd0, 64'd0);
    tbl[2]  = row(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[3]  = row(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[4]  = row(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[5]  = row(1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b1, 64'd1, 64'd0);
    tbl[6]  = row(1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0, 64'd1, 64'd0);
    // overflow: six pings, one popped, four queued, one dropped
    tbl[7]  = row(1'b1, 1'b0, 16'h0001, 8'h01, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[8]  = row(1'b1, 1'b0, 16'h0002, 8'h02, 1'b1, 1'b0, 64'd0, 64'd0);
    tbl[9]  = row(1'b1, 1'b0, 16'h0003, 8'h03, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[10] = row(1'b1, 1'b0, 16'h0004, 8'h04, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[11] = row(1'b1, 1'b0, 16'h0005, 8'h05, 1'b0, 1'b0, 64'd0, 64'd0);
    tbl[12] = row(1'b1, 1'b0, 16'h0006, 8'h06, 1'b0, 1'b0, 64'd0, 64'd1);

    timeout = 32'd100; holdoff = 32'd2;
    do_reset();
    run_table(0, 6);
    chk("single_mac_dst", 64'(mac_addr_dst), 64'(48'h02_00_00_00_00_0A));
    chk("single_id", 64'(tx_ping_id), 64'(16'h0005));
    chk("single_psize", 64'(tx_psize), 64'(16'd64));
    chk("single_mac_src", 64'(mac_addr_src), 64'(OWN_MAC));

    timeout = 32'd1000; holdoff = 32'd0;
    do_reset();
    run_table(7, 12);
    chk("ovf_head_id", 64'(tx_ping_id), 64'(16'h0001));

    // disable while idle with three queued pings
    step(1'b0, mk(16'd0, 16'd0, 8'd0), OWN_MAC, 1'b1, 1'b1);
    idle(2, 1'b1);
    chk("dis_pop_id", 64'(tx_ping_id), 64'(16'h0002));
    step(1'b0, mk(16'd0, 16'd0, 8'd0), OWN_MAC, 1'b1, 1'b1);
    idle(2, 1'b0);
    ntrig = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(16'($urandom), 16'd64, 8'($urandom)), OWN_MAC, 1'b0, 1'b0);
      ntrig += int'(tx_trigger);
    end
    chk("dis_pongs", pongs_sent, 64'd2);
    chk("dis_dropped", pings_dropped, 64'd1);
    chk("dis_timeouts", tx_timeouts, 64'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b1);
      ntrig += int'(tx_trigger);
    end
    chk("dis_no_trigger", 64'(ntrig), 64'd0);
    step(1'b1, mk(16'h0077, 16'd80, 8'h77), OWN_MAC, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("dis_trigger_after_flush", 64'(tx_trigger), 64'd1);
    chk("dis_id_after_flush", 64'(tx_ping_id), 64'(16'h0077));

    // timeout of 10 cycles, then holdoff of 3 before the next queued ping
    timeout = 32'd10; holdoff = 32'd3;
    do_reset();
    step(1'b1, mk(16'h0010, 16'd64, 8'h10), OWN_MAC, 1'b1, 1'b0);
    step(1'b1, mk(16'h0011, 16'd64, 8'h11), OWN_MAC, 1'b1, 1'b0);
    chk("to_trigger", 64'(tx_trigger), 64'd1);
    n = 0;
    do begin idle(1, 1'b1); n++; end while (!done && n < 50);
    chk("to_done_latency", 64'(n), 64'd10);
    chk("to_count", tx_timeouts, 64'd1);
    n = 0;
    do begin idle(1, 1'b1); n++; end while (!tx_trigger && n < 50);
    chk("to_next_trigger", 64'(n), 64'd4);
    chk("to_next_id", 64'(tx_ping_id), 64'(16'h0011));

    // tx_begin in the very cycle count reaches timeout
    timeout = 32'd5; holdoff = 32'd1;
    do_reset();
    step(1'b1, mk(16'h0020, 16'd64, 8'h20), OWN_MAC, 1'b1, 1'b0);
    idle(5, 1'b1);
    step(1'b0, mk(16'd0, 16'd0, 8'd0), OWN_MAC, 1'b1, 1'b1);
    chk("tie_done", 64'(done), 64'd1);
    chk("tie_pongs", pongs_sent, 64'd1);
    chk("tie_timeouts", tx_timeouts, 64'd0);

    // timeout = 0 aborts in the first wait cycle
    timeout = 32'd0; holdoff = 32'd0;
    do_reset();
    step(1'b1, mk(16'h0030, 16'd64, 8'h30), OWN_MAC, 1'b1, 1'b0);
    idle(2, 1'b1);
    chk("to0_done", 64'(done), 64'd1);
    chk("to0_timeouts", tx_timeouts, 64'd1);

`ifdef ETH_PING_RESPONDER_FILTER_EN
    timeout = 32'd100; holdoff = 32'd0;
    do_reset();
    ntrig = 0;
    step(1'b1, mk(16'h0040, 16'd64, 8'h40), 48'h02_00_00_00_00_99, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle(1, 1'b1);
      ntrig += int'(tx_trigger);
    end
    chk("flt_no_trigger", 64'(ntrig), 64'd0);
    chk("flt_dropped", pings_dropped, 64'd0);
    step(1'b1, mk(16'h0041, 16'd64, 8'h41), BCAST, 1'b1, 1'b0);
    idle(1, 1'b1);
    chk("flt_bcast_trigger", 64'(tx_trigger), 64'd1);
    step(1'b0, mk(16'd0, 16'd0, 8'd0), OWN_MAC, 1'b1, 1'b1);
    chk("flt_pongs", pongs_sent, 64'd1);
`endif

    // randomized epochs against the reference model
    for (int e = 0; e < 4; e++) begin
      timeout = $urandom_range(0, 6);
      holdoff = $urandom_range(0, 4);
      do_reset();
      for (int i = 0; i < 800; i++) begin
        r = $urandom_range(0, 2);
        dst = (r == 0) ? OWN_MAC : ((r == 1) ? BCAST : {16'h0200, 32'($urandom)});
        step($urandom_range(0, 99) < 40, mk(16'($urandom), 16'($urandom), 8'($urandom)), dst,
             $urandom_range(0, 99) < 92, $urandom_range(0, 99) < 30);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
